// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: sync/alt blink, chase, bounce and PWM dim.
// Optional macro LED_PATTERN_ACTIVE_LOW_EN inverts the led port for active-low boards.
module led_pattern_gen #(
  parameter int LED_NUM  = 4,
  parameter int STEP_CYC = 10_000_000,
  parameter int DUTY     = 4
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [2:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse
);

  localparam int CW = $clog2(STEP_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYC - 1);
  localparam logic [4:0]    DUTY_TH  = 5'(DUTY);

  localparam logic [2:0] MODE_OFF    = 3'd0;
  localparam logic [2:0] MODE_SYNC   = 3'd1;
  localparam logic [2:0] MODE_ALT    = 3'd2;
  localparam logic [2:0] MODE_CHASE  = 3'd3;
  localparam logic [2:0] MODE_BOUNCE = 3'd4;
  localparam logic [2:0] MODE_DIM    = 3'd5;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         pwm_cnt_q, pwm_cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               dir_q, dir_d;
  logic [LED_NUM-1:0] pat_q, pat_d;
  logic               step_pulse_q, step_pulse_d;
  logic               restart;
  logic               tick;

  function automatic logic [LED_NUM-1:0] init_pat(input logic [2:0] m);
    logic [LED_NUM-1:0] p;
    p = '0;
    case (m)
      MODE_ALT: begin
        for (int i = 0; i < LED_NUM; i += 2) p[i] = 1'b1;
      end
      MODE_CHASE, MODE_BOUNCE: p[0] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    restart      = valid & (~valid_q | (mode != mode_q));
    tick         = valid & (cnt_q == CNT_LAST);
    mode_d       = mode;
    valid_d      = valid;
    cnt_d        = cnt_q;
    pwm_cnt_d    = pwm_cnt_q;
    dir_d        = dir_q;
    pat_d        = pat_q;
    step_pulse_d = 1'b0;

    if (!valid) begin
      cnt_d     = '0;
      pwm_cnt_d = '0;
      dir_d     = DIR_UP;
      pat_d     = '0;
    end else if (restart) begin
      // A new mode or a fresh enable discards any partial step.
      cnt_d     = '0;
      pwm_cnt_d = '0;
      dir_d     = DIR_UP;
      pat_d     = init_pat(mode);
    end else begin
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      case (mode)
        MODE_SYNC, MODE_ALT: begin
          if (tick) pat_d = ~pat_q;
          step_pulse_d = tick;
        end
        MODE_CHASE: begin
          if (tick) pat_d = (pat_q << 1) | (pat_q >> (LED_NUM - 1));
          step_pulse_d = tick;
        end
        MODE_BOUNCE: begin
          // Direction flips on arrival at an end so each end is lit for one step only.
          if (tick && LED_NUM > 1) begin
            if (dir_q == DIR_UP) begin
              pat_d = pat_q << 1;
              if (pat_d[LED_NUM-1]) dir_d = DIR_DOWN;
            end else begin
              pat_d = pat_q >> 1;
              if (pat_d[0]) dir_d = DIR_UP;
            end
          end
          step_pulse_d = tick;
        end
        MODE_DIM: begin
          pat_d        = ({1'b0, pwm_cnt_q} < DUTY_TH) ? '1 : '0;
          step_pulse_d = tick;
        end
        default: pat_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_q        <= '0;
      pwm_cnt_q    <= '0;
      mode_q       <= MODE_OFF;
      valid_q      <= 1'b0;
      dir_q        <= DIR_UP;
      pat_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      mode_q       <= mode_d;
      valid_q      <= valid_d;
      dir_q        <= dir_d;
      pat_q        <= pat_d;
      step_pulse_q <= step_pulse_d;
    end
  end

`ifdef LED_PATTERN_ACTIVE_LOW_EN
  assign led = ~pat_q;
`else
  assign led = pat_q;
`endif
  assign step_pulse = step_pulse_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED pattern generator; next generation of the fixed 4-LED 0.2 s flasher.
- Drives LED_NUM outputs in one of several runtime-selectable modes: sync blink, alternate blink, chase, bounce, PWM dim.
- Step rate and channel count are set by parameters.
- Sits at board top level between control logic (valid/mode) and the LED pins; step_pulse is available to other blocks for synchronisation.

Parameters:
- LED_NUM, 4, number of LED channels (>=1).
- STEP_CYC, 10_000_000, sys_clk cycles per pattern step (>=2); 0.2 s at 50 MHz.
- DUTY, 4, PWM on-time in mode 5, out of 16 (0..16).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous reset, active-high.
- valid  input  1  enable; 1 = run pattern, 0 = LEDs off.
- mode  input  3  pattern select, see Behaviour.
- led  output  LED_NUM  registered LED drive, 1 = on.
- step_pulse  output  1  one-cycle strobe on each pattern step.

Behaviour:
- All state updates on posedge sys_clk. Reset is synchronous, active-high, and has priority over everything.
- Reset values: led=0, step_pulse=0, cnt=0, pwm_cnt=0, mode_q=0, valid_q=0, dir=up.
- cnt is $clog2(STEP_CYC) bits wide.
  - valid=1: counts 0..STEP_CYC-1, then wraps to 0.
  - valid=0: held at 0.
  - tick = valid & (cnt==STEP_CYC-1).
- mode_q<=mode and valid_q<=valid every cycle.
- restart = valid & (!valid_q | mode!=mode_q). This covers valid rising or mode changing while running.
- On restart: cnt<=0, pwm_cnt<=0, dir<=up, led<=init(mode). This gives one-cycle latency from an input change to the new initial pattern.
- First step after restart occurs STEP_CYC cycles later.
- restart has priority over tick in the same cycle.
- valid=0: led<=0, step_pulse<=0, pattern state frozen at initial values.
- step_pulse<=tick & (mode!=0) & !restart. It is high in the same cycle led updates.
- Modes (init pattern / action on tick):
  - 0 OFF: led=0; ticks ignored.
  - 1 SYNC: init all 0; tick inverts all bits.
  - 2 ALT: init even bits 1, odd bits 0 (4 LEDs: 0101); tick inverts all bits.
  - 3 CHASE: init one-hot bit0; tick rotates left, bit LED_NUM-1 wraps to bit0.
  - 4 BOUNCE: init one-hot bit0, dir=up.
    - tick moves one position in dir.
    - On reaching bit LED_NUM-1, dir<=down; on reaching bit0, dir<=up. No dwell: each end is lit for exactly one step. Sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,...
    - LED_NUM=1: stays 1.
  - 5 DIM: pwm_cnt is 4-bit, free-running while valid. All led bits are registered (pwm_cnt<DUTY). DUTY=0 gives always off; DUTY=16 gives always on. Ticks still advance cnt and step_pulse.
  - 6, 7: reserved; behave as OFF (led=0, no step_pulse).
- Mode change mid-step: the partial step is discarded via restart; no glitch beyond the one-cycle latency.
- Reset mid-operation: all outputs return to reset values on the next edge.

Optional Feature:
- Macro LED_PATTERN_ACTIVE_LOW_EN.
- Defined: led port is the bitwise inverse of the internal pattern, for boards with active-low LEDs. Reset value is all ones; valid=0 and OFF modes also drive all ones. step_pulse is unaffected.
- Undefined: active-high as described above.

Test Plan:
- Bench parameters for all scenarios: LED_NUM=4, STEP_CYC=4, DUTY=4.
- Scenario 1, reset and sync blink:
  - Stimulus: rst=1 for 3 cycles with valid=1, mode=1; then rst=0.
  - Response: led=0000 during reset. Restart cycle gives led=0000. Then led=1111 after 4 cycles, 0000 after 8 cycles, with step_pulse high exactly in those cycles.
- Scenario 2, chase wrap:
  - Stimulus: mode=3, valid=1.
  - Response: led=0001,0010,0100,1000,0001, each held 4 cycles; step_pulse period 4.
- Scenario 3, bounce end reversal:
  - Stimulus: mode=4.
  - Response: led=0001,0010,0100,1000,0100,0010,0001,0010; no repeated 1000 or 0001.
- Scenario 4, mode change mid-step:
  - Stimulus: mode=3 at led=0100 with cnt=2; switch to mode=2.
  - Response: next cycle led=0101 and cnt=0. Invert to 1010 after 4 more cycles. No step_pulse in the restart cycle.
- Scenario 5, PWM dim and valid drop:
  - Stimulus: mode=5 for 32 cycles, then valid=0.
  - Response: led=1111 for 4 of every 16 cycles, 0000 otherwise. After valid drop: led=0000 next cycle and step_pulse stays 0.
  - On re-assertion of valid: led=0000 and the PWM phase restarts at pwm_cnt=0.
- Scenario 6, active-low build:
  - Stimulus: LED_PATTERN_ACTIVE_LOW_EN defined; repeat scenario 2.
  - Response: led=1110,1101,1011,0111; reset value 1111.
